// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
//   Registered, handshaked two-operand bitwise logic ALU.
//   A command (mode, op_a, op_b, a, b) is taken when in_valid && in_ready.
//   It is decoded at acceptance and travels through PIPE_DEPTH valid-tagged
//   stages to the output. Commands with alu_enable = 0 are consumed but
//   produce no output beat. A sticky interrupt is raised whenever a beat
//   with a zero result or an error transfers downstream.
//
//   PIPE_DEPTH must be 1 or 2.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   command valid
//   in_ready   core can accept a command this cycle
//   mode       {enable_a, enable_b, alu_enable}
//   op_a       A-group op: 00 AND, 01 NAND, 10 OR, 11 XOR
//   op_b       B-group op: 00 XNOR, 01 AND, 10 NOR, 11 OR
//   a, b       operands
//   out_valid  result valid
//   out_ready  downstream accepts result
//   result     computed value
//   err        illegal-mode flag, qualified by out_valid
//   irq        sticky interrupt
//   irq_clr    clears irq (set wins on the same edge)
// -----------------------------------------------------------------------------
module alu_core #(
    parameter int DATA_W     = 8,
    parameter int PIPE_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        mode,
    input  logic [1:0]        op_a,
    input  logic [1:0]        op_b,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              err,
    output logic              irq,
    input  logic              irq_clr
);

    localparam int LAST = PIPE_DEPTH - 1;

    logic [PIPE_DEPTH-1:0] valid_q;
    logic [DATA_W-1:0]     res_q [PIPE_DEPTH];
    logic                  err_q [PIPE_DEPTH];

    // take[i]: stage i may load this cycle (it is empty or it is advancing).
    logic [PIPE_DEPTH-1:0] take;

    // Holds in_ready low until the first edge after reset release.
    logic                  run_q;

    logic                  irq_q;
    logic                  irq_d;

    logic [DATA_W-1:0]     dec_res;
    logic                  dec_err;
    logic                  xfer;

    // A stage can load if out_ready is high or any stage from it to the
    // output is empty; this is the unrolled "empty or next advancing" chain.
    // It depends only on valid bits and out_ready, never on in_valid.
    genvar gi;
    generate
        for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_take
            assign take[gi] = out_ready || !(&valid_q[PIPE_DEPTH-1:gi]);
        end
    endgenerate

    assign in_ready = run_q && take[0];

    // Mode / op decode at acceptance.
    always_comb begin
        dec_res = '0;
        dec_err = 1'b0;
        case (mode)
            3'b101: begin
                case (op_a)
                    2'b00:   dec_res = a & b;
                    2'b01:   dec_res = ~(a & b);
                    2'b10:   dec_res = a | b;
                    default: dec_res = a ^ b;
                endcase
            end
            3'b011: begin
                case (op_b)
                    2'b00:   dec_res = ~(a ^ b);
                    2'b01:   dec_res = a & b;
                    2'b10:   dec_res = ~(a | b);
                    default: dec_res = a | b;
                endcase
            end
            // 111 and 001 are illegal; alu_enable = 0 modes never load a beat.
            default: dec_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                res_q[i] <= '0;
                err_q[i] <= 1'b0;
            end
        end else begin
            // Stage 0: dropped commands are consumed but leave the stage empty.
            if (in_ready) begin
                valid_q[0] <= in_valid && mode[0];
                if (in_valid && mode[0]) begin
                    res_q[0] <= dec_res;
                    err_q[0] <= dec_err;
                end
            end
            // Later stages: payload only moves with a valid beat, so an empty
            // output stage keeps its last result/err.
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                if (take[i]) begin
                    valid_q[i] <= valid_q[i-1];
                    if (valid_q[i-1]) begin
                        res_q[i] <= res_q[i-1];
                        err_q[i] <= err_q[i-1];
                    end
                end
            end
        end
    end

    assign out_valid = valid_q[LAST];
    assign result    = res_q[LAST];
    assign err       = err_q[LAST];

    assign xfer = valid_q[LAST] && out_ready;

    // Set has priority over clear.
    always_comb begin
        irq_d = irq_q;
        if (irq_clr) begin
            irq_d = 1'b0;
        end
        if (xfer && ((res_q[LAST] == '0) || err_q[LAST])) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_alu_core.sv
module tb_alu_core;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance with PIPE_DEPTH = 2
    logic       iv2 = 1'b0, ordy2 = 1'b0, clr2 = 1'b0;
    logic [2:0] m2 = 3'b000;
    logic [1:0] oa2 = 2'b00, ob2 = 2'b00;
    logic [7:0] a2 = 8'h00, b2 = 8'h00;
    logic       ir2, ov2, er2, irq2;
    logic [7:0] res2;

    // Instance with PIPE_DEPTH = 1
    logic       iv1 = 1'b0, ordy1 = 1'b0, clr1 = 1'b0;
    logic [2:0] m1 = 3'b000;
    logic [1:0] oa1 = 2'b00, ob1 = 2'b00;
    logic [7:0] a1 = 8'h00, b1 = 8'h00;
    logic       ir1, ov1, er1, irq1;
    logic [7:0] res1;

    int checks = 0;
    int errors = 0;
    int beats2 = 0;
    int b0;

    alu_core #(.DATA_W(8), .PIPE_DEPTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv2), .in_ready(ir2),
        .mode(m2), .op_a(oa2), .op_b(ob2), .a(a2), .b(b2),
        .out_valid(ov2), .out_ready(ordy2),
        .result(res2), .err(er2), .irq(irq2), .irq_clr(clr2)
    );

    alu_core #(.DATA_W(8), .PIPE_DEPTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv1), .in_ready(ir1),
        .mode(m1), .op_a(oa1), .op_b(ob1), .a(a1), .b(b1),
        .out_valid(ov1), .out_ready(ordy1),
        .result(res1), .err(er1), .irq(irq1), .irq_clr(clr1)
    );

    // Count output transfers of the depth-2 instance.
    always @(posedge clk) begin
        if (ov2 && ordy2) beats2 <= beats2 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input logic [2:0] m, input logic [1:0] oa, input logic [1:0] ob,
                          input logic [7:0] av, input logic [7:0] bv);
        iv2 = 1'b1; m2 = m; oa2 = oa; ob2 = ob; a2 = av; b2 = bv;
        $display("cmd2 mode=%b op_a=%b op_b=%b a=%h b=%h", m, oa, ob, av, bv);
    endtask

    // Reference: {err, result}
    function automatic logic [8:0] model(input logic [2:0] m, input logic [1:0] oa,
                                         input logic [1:0] ob, input logic [7:0] av,
                                         input logic [7:0] bv);
        logic [7:0] r;
        r = 8'h00;
        if (m == 3'b101) begin
            if (oa == 2'b00) r = av & bv;
            else if (oa == 2'b01) r = ~(av & bv);
            else if (oa == 2'b10) r = av | bv;
            else r = av ^ bv;
            return {1'b0, r};
        end else if (m == 3'b011) begin
            if (ob == 2'b00) r = ~(av ^ bv);
            else if (ob == 2'b01) r = av & bv;
            else if (ob == 2'b10) r = ~(av | bv);
            else r = av | bv;
            return {1'b0, r};
        end
        return {1'b1, 8'h00};
    endfunction

    initial begin
        logic [7:0] exp_res [4];
        logic [8:0] e;

        // ---------------- reset ----------------
        repeat (2) cyc();
        chk("rst_in_ready", ir2, 1'b0);
        chk("rst_out_valid", ov2, 1'b0);
        chk("rst_irq", irq2, 1'b0);
        chk("rst_result", res2, 8'h00);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_low", ir2, 1'b0);
        cyc();
        chk("rel_in_ready_high", ir2, 1'b1);
        chk("rel_in_ready_high_d1", ir1, 1'b1);

        // ---------------- 1: A mode XOR, latency 2 ----------------
        ordy2 = 1'b1;
        drive2(3'b101, 2'b11, 2'b00, 8'hF0, 8'h3C);
        cyc();
        iv2 = 1'b0;
        chk("t1_not_yet", ov2, 1'b0);
        cyc();
        chk("t1_valid", ov2, 1'b1);
        chk("t1_result", res2, 8'hCC);
        chk("t1_err", er2, 1'b0);
        chk("t1_irq", irq2, 1'b0);
        cyc();
        chk("t1_drained", ov2, 1'b0);
        chk("t1_irq_after", irq2, 1'b0);

        // ---------------- 2: B mode NOR zero, irq ----------------
        drive2(3'b011, 2'b00, 2'b10, 8'hFF, 8'h00);
        cyc();
        iv2 = 1'b0;
        cyc();
        chk("t2_valid", ov2, 1'b1);
        chk("t2_result", res2, 8'h00);
        chk("t2_err", er2, 1'b0);
        chk("t2_irq_before", irq2, 1'b0);
        cyc();
        chk("t2_irq_set", irq2, 1'b1);
        cyc();
        chk("t2_irq_sticky", irq2, 1'b1);
        clr2 = 1'b1;
        cyc();
        clr2 = 1'b0;
        chk("t2_irq_cleared", irq2, 1'b0);
        drive2(3'b011, 2'b00, 2'b10, 8'hFF, 8'h00);
        cyc();
        iv2 = 1'b0;
        cyc();
        chk("t2b_valid", ov2, 1'b1);
        chk("t2b_irq_before", irq2, 1'b0);
        clr2 = 1'b1;
        cyc();
        clr2 = 1'b0;
        chk("t2b_set_wins", irq2, 1'b1);
        clr2 = 1'b1;
        cyc();
        clr2 = 1'b0;
        chk("t2b_irq_cleared", irq2, 1'b0);

        // ---------------- 3: illegal + dropped + A AND ----------------
        b0 = beats2;
        drive2(3'b111, 2'b00, 2'b00, 8'h12, 8'h34);
        cyc();
        drive2(3'b000, 2'b00, 2'b00, 8'h56, 8'h78);
        cyc();
        chk("t3_b1_valid", ov2, 1'b1);
        chk("t3_b1_err", er2, 1'b1);
        chk("t3_b1_result", res2, 8'h00);
        drive2(3'b101, 2'b00, 2'b00, 8'hAA, 8'h0F);
        cyc();
        iv2 = 1'b0;
        chk("t3_no_gap_beat", ov2, 1'b0);
        chk("t3_irq", irq2, 1'b1);
        cyc();
        chk("t3_b2_valid", ov2, 1'b1);
        chk("t3_b2_result", res2, 8'h0A);
        chk("t3_b2_err", er2, 1'b0);
        cyc();
        chk("t3_drained", ov2, 1'b0);
        cyc();
        chk("t3_beat_count", beats2 - b0, 2);
        clr2 = 1'b1;
        cyc();
        clr2 = 1'b0;

        // ---------------- 4: backpressure ----------------
        b0 = beats2;
        for (int k = 0; k < 4; k++) exp_res[k] = (8'h11 * (k + 1)) | 8'h0F;
        ordy2 = 1'b0;
        drive2(3'b101, 2'b10, 2'b00, 8'h11, 8'h0F);
        #1;
        chk("t4_ready0", ir2, 1'b1);
        cyc();
        chk("t4_ready1", ir2, 1'b1);
        drive2(3'b101, 2'b10, 2'b00, 8'h22, 8'h0F);
        cyc();
        chk("t4_full_ready", ir2, 1'b0);
        chk("t4_hold_valid", ov2, 1'b1);
        chk("t4_hold_res0", res2, exp_res[0]);
        drive2(3'b101, 2'b10, 2'b00, 8'h33, 8'h0F);
        cyc();
        chk("t4_stall_ready", ir2, 1'b0);
        chk("t4_stall_res1", res2, exp_res[0]);
        cyc();
        chk("t4_stall_valid2", ov2, 1'b1);
        chk("t4_stall_res2", res2, exp_res[0]);
        ordy2 = 1'b1;
        #1;
        chk("t4_ready_comb", ir2, 1'b1);
        cyc();
        chk("t4_drain_res1", res2, exp_res[1]);
        drive2(3'b101, 2'b10, 2'b00, 8'h44, 8'h0F);
        cyc();
        iv2 = 1'b0;
        chk("t4_drain_res2", res2, exp_res[2]);
        cyc();
        chk("t4_drain_res3", res2, exp_res[3]);
        chk("t4_drain_valid3", ov2, 1'b1);
        cyc();
        chk("t4_empty", ov2, 1'b0);
        chk("t4_beat_count", beats2 - b0, 4);

        // ---------------- 5: reset mid-flight ----------------
        drive2(3'b001, 2'b00, 2'b00, 8'h01, 8'h02);
        cyc();
        iv2 = 1'b0;
        cyc();
        chk("t5_err_beat", er2, 1'b1);
        cyc();
        chk("t5_irq_set", irq2, 1'b1);
        ordy2 = 1'b0;
        drive2(3'b101, 2'b10, 2'b00, 8'h55, 8'h0F);
        cyc();
        drive2(3'b101, 2'b10, 2'b00, 8'h66, 8'h0F);
        cyc();
        iv2 = 1'b0;
        chk("t5_full_valid", ov2, 1'b1);
        chk("t5_full_ready", ir2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_out_valid", ov2, 1'b0);
        chk("t5_rst_in_ready", ir2, 1'b0);
        chk("t5_rst_irq", irq2, 1'b0);
        b0 = beats2;
        ordy2 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t5_no_stale", ov2, 1'b0);
        end
        chk("t5_beat_count", beats2 - b0, 0);
        chk("t5_ready_back", ir2, 1'b1);

        // ---------------- 6: PIPE_DEPTH = 1 throughput ----------------
        ordy1 = 1'b1;
        for (int k = 0; k < 100; k++) begin
            m1  = ($urandom_range(0, 1) == 1) ? 3'b101 : 3'b011;
            oa1 = 2'($urandom_range(0, 3));
            ob1 = 2'($urandom_range(0, 3));
            a1  = 8'($urandom_range(0, 255));
            b1  = 8'($urandom_range(0, 255));
            iv1 = 1'b1;
            e = model(m1, oa1, ob1, a1, b1);
            chk("t6_in_ready", ir1, 1'b1);
            cyc();
            $display("cmd1 #%0d mode=%b op_a=%b op_b=%b exp=%h got=%h", k, m1, oa1, ob1, e[7:0], res1);
            chk("t6_valid", ov1, 1'b1);
            chk("t6_result", res1, e[7:0]);
            chk("t6_err", er1, e[8]);
        end
        iv1 = 1'b0;
        cyc();
        chk("t6_empty", ov1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- Registered, handshaked two-operand logic ALU.
- Consumes the command stream (mode, op_a, op_b, a, b) that the team's bench stimulus generates, and returns results plus an error flag.
- Raises a sticky interrupt on zero or error results.
- Acts as the responder/DUT side of the existing operation_mode / alu_op_a / alu_op_b encoding.

Parameters:
DATA_W, 8, operand and result width in bits
PIPE_DEPTH, 2, input-to-output latency in cycles; legal values are 1 or 2

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  command valid
in_ready  output  1  core can accept a command this cycle
mode  input  3  {enable_a, enable_b, alu_enable}; bit2 = enable_a, bit1 = enable_b, bit0 = alu_enable
op_a  input  2  A-group op: 00 AND, 01 NAND, 10 OR, 11 XOR
op_b  input  2  B-group op: 00 XNOR, 01 AND, 10 NOR, 11 OR
a  input  DATA_W  operand A
b  input  DATA_W  operand B
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
result  output  DATA_W  computed value
err  output  1  illegal-mode flag, qualified by out_valid
irq  output  1  sticky interrupt
irq_clr  input  1  clears irq

Behaviour:
- Reset: all outputs 0 immediately on rst_n low, including in_ready; pipeline emptied.
  - in_ready rises on the first clk edge after rst_n deasserts.
  - Reset mid-operation discards all in-flight commands; no partial output is produced.
- Accept: a command is taken on a rising edge when in_valid && in_ready. Operands are sampled only at acceptance.
- Mode decode (at acceptance):
  - 101 (A mode): result = op_a function of a, b; err = 0.
  - 011 (B mode): result = op_b function of a, b; err = 0.
  - 111 (both enables): result = 0; err = 1.
  - alu_enable = 0 (000, 010, 100, 110): command is consumed but no output beat is produced; it does not count toward latency or irq.
  - 001 (no group enabled): result = 0; err = 1.
- Width: bitwise ops only; result is exactly DATA_W bits; no carry or overflow.
- Pipeline:
  - PIPE_DEPTH stages, each with a valid bit. With out_ready held high, the result appears PIPE_DEPTH cycles after acceptance.
  - Full throughput is 1 command per cycle.
  - Backpressure:
    - A stage advances when the next stage is empty or advancing.
    - The last stage holds result, err and out_valid stable while out_valid && !out_ready.
    - in_ready = first stage empty || first stage advancing.
    - in_ready is combinational from out_ready; there is no combinational path from in_valid to in_ready.
  - Full: when all stages are valid and out_ready = 0, in_ready = 0; in_valid is ignored.
  - Empty: out_valid = 0; result and err hold their last values, and the bench must not check them.
- irq:
  - Set on the edge where an output beat transfers (out_valid && out_ready) with result == 0 or err == 1.
  - Cleared on the edge where irq_clr = 1.
  - If a set and a clear fall on the same edge, set wins and irq stays 1.
  - irq_clr has no effect on the pipeline.
- Ordering: outputs are emitted strictly in acceptance order; dropped (alu_enable = 0) commands leave no gap.

Test Plan:
1. Reset then A mode, PIPE_DEPTH = 2, out_ready = 1: mode = 101, op_a = 11, a = 8'hF0, b = 8'h3C accepted at cycle 0 -> out_valid at cycle 2, result = 8'hCC, err = 0, irq = 0.
2. B mode and zero irq: mode = 011, op_b = 10 (NOR), a = 8'hFF, b = 8'h00 -> result = 8'h00, err = 0; irq rises on the transfer edge and stays 1 until irq_clr is pulsed; with irq_clr = 1 on the same edge as a new zero-result transfer, irq remains 1.
3. Illegal and dropped commands: send 111, 000, 101/op_a = 00 (a = 8'hAA, b = 8'h0F) back-to-back ->
   - first beat: err = 1, result = 0;
   - second beat: result = 8'h0A, err = 0;
   - exactly 2 output beats total; irq = 1 after the first beat.
4. Backpressure: out_ready = 0, stream 4 valid A-mode commands -> in_ready drops after 2 accepts and out_valid holds the first result stable. Then raise out_ready -> the remaining results drain in order at 1 per cycle, with no loss or duplication.
5. Reset mid-flight: 2 commands in pipeline, assert rst_n low asynchronously between edges -> out_valid, in_ready and irq drop to 0 immediately; after release no stale beat appears.
6. Throughput, PIPE_DEPTH = 1: 100 random legal commands with in_valid and out_ready held at 1 -> one result per cycle at 1-cycle latency, all matching the reference model.
